// File: rtl/time_pkg.sv
// Shared definitions for the clock/calendar time fields: key FSM states,
// a ceiling-log2 width helper and the largest legal BCD digit.
package time_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_HOLD   = 2'd1,
    KEY_REPEAT = 2'd2
  } key_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_field_counter_bin2bcd.sv
// Combinational two-digit binary to BCD converter for values 0..99,
// shared by the hour and minute fields.
module bin2bcd_2dig
  import time_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] i_bin,
  output logic [7:0]   o_bcd
);

  logic [7:0] w_rem;
  logic [3:0] w_tens;

  // Repeated subtraction of ten; nine passes cover the whole 0..99 range.
  always_comb begin
    w_rem  = 8'(i_bin);
    w_tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (w_rem >= 8'd10) begin
        w_rem  = w_rem - 8'd10;
        w_tens = w_tens + 4'd1;
      end else begin
        w_rem  = w_rem;
      end
    end
    o_bcd = {w_tens, w_rem[3:0]};
  end

endmodule

// File: rtl/time_field_counter.sv
// One time field (seconds, minutes, hours...): wraps at MAX, advanced by a
// run-mode tick or by up/down keys with auto-repeat in set mode, BCD loadable.
module time_field_counter
  import time_pkg::*;
#(
  parameter int MAX         = 59,
  parameter int SEL_ID      = 1,
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 12_500_000,
  localparam int W          = clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   sel,
  input  logic         up,
  input  logic         down,
  input  logic         run,
  input  logic         tick,
  input  logic         load,
  input  logic [7:0]   load_bcd,
  output logic [W-1:0] value,
  output logic [7:0]   bcd,
  output logic         carry_out,
  output logic         borrow_out,
  output logic         load_err
);

  localparam int            CNT_SPAN  = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int            CW        = clog2(CNT_SPAN);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [W-1:0]  MAX_V     = W'(MAX);
  localparam logic [7:0]    MAX_8     = 8'(MAX);
  localparam logic [3:0]    SEL_V     = 4'(SEL_ID);

  logic [W-1:0]  r_value, w_value_nxt;
  logic          r_carry, w_carry_nxt;
  logic          r_borrow, w_borrow_nxt;
  logic          r_err, w_err_nxt;
  logic          r_up_q, r_down_q;
  logic          r_armed;
  key_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dir_up, w_dir_up_nxt;
  logic          w_step_up, w_step_dn;

  logic          w_set_en, w_up_rise, w_dn_rise, w_held;
  logic          w_load_ok;
  logic [7:0]    w_load_num;
  logic [W-1:0]  w_inc_val, w_dec_val;
  logic          w_inc_wrap, w_dec_wrap;

  assign w_set_en  = ~run & (sel == SEL_V);
  // r_armed spends the first cycle after reset sampling the keys, so a key
  // held through reset release is not mistaken for a fresh press.
  assign w_up_rise = r_armed & up & ~r_up_q;
  assign w_dn_rise = r_armed & down & ~r_down_q;
  assign w_held    = r_dir_up ? (up & ~down) : (down & ~up);

  assign w_load_num = ({4'd0, load_bcd[7:4]} * 8'd10) + {4'd0, load_bcd[3:0]};
  assign w_load_ok  = (load_bcd[7:4] <= BCD_DIGIT_MAX) && (load_bcd[3:0] <= BCD_DIGIT_MAX)
                      && (w_load_num <= MAX_8);

  assign w_inc_wrap = (r_value == MAX_V);
  assign w_dec_wrap = (r_value == {W{1'b0}});
  assign w_inc_val  = w_inc_wrap ? {W{1'b0}} : r_value + W'(1);
  assign w_dec_val  = w_dec_wrap ? MAX_V : r_value - W'(1);

  // Key FSM next state: single step on press, delayed then periodic repeat.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_up_nxt = r_dir_up;
    w_step_up    = 1'b0;
    w_step_dn    = 1'b0;
    case (r_state)
      KEY_IDLE: begin
        w_cnt_nxt = {CW{1'b0}};
        if (!w_set_en) begin
          w_state_nxt = KEY_IDLE;
        end else if (w_up_rise && !down) begin
          w_step_up    = 1'b1;
          w_dir_up_nxt = 1'b1;
          w_state_nxt  = KEY_HOLD;
        end else if (w_dn_rise && !up) begin
          w_step_dn    = 1'b1;
          w_dir_up_nxt = 1'b0;
          w_state_nxt  = KEY_HOLD;
        end else begin
          w_state_nxt = KEY_IDLE;
        end
      end
      KEY_HOLD, KEY_REPEAT: begin
        if (!w_set_en || !w_held) begin
          w_state_nxt = KEY_IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else if (r_cnt == ((r_state == KEY_HOLD) ? DLY_LAST : RATE_LAST)) begin
          w_step_up   = r_dir_up;
          w_step_dn   = ~r_dir_up;
          w_state_nxt = KEY_REPEAT;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = KEY_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Value update: load beats a key step beats a run tick; one change per cycle.
  always_comb begin
    w_value_nxt  = r_value;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_value_nxt = w_load_num[W-1:0];
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (w_step_up || (run && tick)) begin
      w_value_nxt = w_inc_val;
      w_carry_nxt = w_inc_wrap;
    end else if (w_step_dn) begin
      w_value_nxt  = w_dec_val;
      w_borrow_nxt = w_dec_wrap;
    end else begin
      w_value_nxt = r_value;
    end
  end

  // State, key history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value  <= {W{1'b0}};
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
      r_up_q   <= 1'b0;
      r_down_q <= 1'b0;
      r_armed  <= 1'b0;
      r_state  <= KEY_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_dir_up <= 1'b0;
    end else begin
      r_value  <= w_value_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
      r_err    <= w_err_nxt;
      r_up_q   <= up;
      r_down_q <= down;
      r_armed  <= 1'b1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_up <= w_dir_up_nxt;
    end
  end

  bin2bcd_2dig #(.W(W)) u_bin2bcd (
    .i_bin (r_value),
    .o_bcd (bcd)
  );

  assign value      = r_value;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign load_err   = r_err;

endmodule

// File: tb/tb_time_field_counter.sv
// Directed bench for time_field_counter with MAX=59, SEL_ID=1,
// REPEAT_DLY=8, REPEAT_RATE=4.
module tb_time_field_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sel;
  logic       up, down, run, tick, load;
  logic [7:0] load_bcd;
  logic [5:0] value;
  logic [7:0] bcd;
  logic       carry_out, borrow_out, load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_field_counter #(
    .MAX         (59),
    .SEL_ID      (1),
    .REPEAT_DLY  (8),
    .REPEAT_RATE (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .up         (up),
    .down       (down),
    .run        (run),
    .tick       (tick),
    .load       (load),
    .load_bcd   (load_bcd),
    .value      (value),
    .bcd        (bcd),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .load_err   (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = 4'd0; up = 1'b0; down = 1'b0; run = 1'b0;
    tick = 1'b0; load = 1'b0; load_bcd = 8'h00;
    #3;
    chk("rst_value", value, 32'd0);
    chk("rst_bcd", bcd, 32'h00);
    chk("rst_flags", {carry_out, borrow_out, load_err}, 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Run mode: 58 -> 59 -> 0 with one carry pulse
    run = 1'b1; load = 1'b1; load_bcd = 8'h58;
    cyc(1);
    load = 1'b0;
    chk("load58_value", value, 32'd58);
    chk("load58_bcd", bcd, 32'h58);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("tick1_value", value, 32'd59);
    chk("tick1_bcd", bcd, 32'h59);
    chk("tick1_carry", carry_out, 32'd0);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("tick2_value", value, 32'd0);
    chk("tick2_bcd", bcd, 32'h00);
    chk("tick2_carry", carry_out, 32'd1);
    cyc(1);
    chk("tick2_carry_end", carry_out, 32'd0);
    // Keys ignored in run mode
    sel = 4'd1; up = 1'b1;
    cyc(2);
    up = 1'b0;
    cyc(1);
    chk("run_ignores_up", value, 32'd0);

    // Set mode: down from 0 wraps to 59 with borrow
    run = 1'b0;
    cyc(1);
    down = 1'b1;
    cyc(1);
    down = 1'b0;
    chk("down_wrap_value", value, 32'd59);
    chk("down_wrap_bcd", bcd, 32'h59);
    chk("down_wrap_borrow", borrow_out, 32'd1);
    cyc(1);
    chk("down_borrow_end", borrow_out, 32'd0);
    cyc(10);
    chk("down_idle_hold", value, 32'd59);

    // Auto-repeat from 10: steps at +0, +8, +12, +16, +20
    load = 1'b1; load_bcd = 8'h10;
    cyc(1);
    load = 1'b0;
    chk("load10", value, 32'd10);
    up = 1'b1;
    cyc(1);
    chk("rep_press", value, 32'd11);
    cyc(7);
    chk("rep_before_dly", value, 32'd11);
    cyc(1);
    chk("rep_at_dly", value, 32'd12);
    cyc(3);
    chk("rep_before_rate", value, 32'd12);
    cyc(1);
    chk("rep_at_12", value, 32'd13);
    cyc(4);
    chk("rep_at_16", value, 32'd14);
    cyc(4);
    chk("rep_at_20", value, 32'd15);
    up = 1'b0;
    cyc(6);
    chk("rep_release", value, 32'd15);

    // Wrong field selected, then both keys together
    sel = 4'd2; up = 1'b1;
    cyc(3);
    up = 1'b0;
    cyc(1);
    chk("sel_mismatch", value, 32'd15);
    sel = 4'd1; up = 1'b1; down = 1'b1;
    cyc(12);
    up = 1'b0; down = 1'b0;
    cyc(1);
    chk("both_keys", value, 32'd15);

    // Loads: legal, out of range, bad digit, boundary
    load = 1'b1; load_bcd = 8'h45;
    cyc(1);
    load = 1'b0;
    chk("load45_value", value, 32'd45);
    chk("load45_bcd", bcd, 32'h45);
    chk("load45_err", load_err, 32'd0);
    load = 1'b1; load_bcd = 8'h60;
    cyc(1);
    load = 1'b0;
    chk("load60_err", load_err, 32'd1);
    chk("load60_hold", value, 32'd45);
    cyc(1);
    chk("load60_err_end", load_err, 32'd0);
    load = 1'b1; load_bcd = 8'h3A;
    cyc(1);
    load = 1'b0;
    chk("load3A_err", load_err, 32'd1);
    chk("load3A_hold", value, 32'd45);
    load = 1'b1; load_bcd = 8'h59;
    cyc(1);
    load = 1'b0;
    chk("load59_value", value, 32'd59);
    chk("load59_err", load_err, 32'd0);
    run = 1'b1; tick = 1'b1; load = 1'b1; load_bcd = 8'h07;
    cyc(1);
    load = 1'b0; tick = 1'b0;
    chk("load_vs_tick", value, 32'd7);
    chk("load_vs_tick_carry", carry_out, 32'd0);
    run = 1'b0;
    cyc(1);

    // Reset in the middle of auto-repeat with the key held
    up = 1'b1;
    cyc(1);
    chk("pre_rst_press", value, 32'd8);
    cyc(8);
    chk("pre_rst_dly", value, 32'd9);
    cyc(2);
    reset = 1'b1;
    #2;
    chk("async_rst_value", value, 32'd0);
    chk("async_rst_bcd", bcd, 32'h00);
    cyc(2);
    reset = 1'b0;
    cyc(4);
    chk("held_through_rst", value, 32'd0);
    up = 1'b0;
    cyc(2);
    up = 1'b1;
    cyc(1);
    chk("repress_after_rst", value, 32'd1);
    up = 1'b0;
    cyc(2);

    // Set-mode up wrap gives a carry
    load = 1'b1; load_bcd = 8'h59;
    cyc(1);
    load = 1'b0;
    up = 1'b1;
    cyc(1);
    up = 1'b0;
    chk("set_up_wrap_value", value, 32'd0);
    chk("set_up_wrap_carry", carry_out, 32'd1);
    cyc(1);
    chk("set_up_carry_end", carry_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_field_counter.md
TIME_FIELD_COUNTER -- requirements
Module: time_field_counter

Interface
REQ-001 SHALL have parameter MAX, default 59: terminal count, legal range 1..99.
REQ-002 SHALL have parameter SEL_ID, default 1: value of sel that enables set mode for this field.
REQ-003 SHALL have parameter REPEAT_DLY, default 50_000_000: cycles an up or down key is held before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_RATE, default 12_500_000: cycles between auto-repeat steps.
REQ-005 SHALL have local width W = clog2(MAX+1).
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port sel, input, 4: field-select code.
REQ-009 SHALL have port up, input, 1: increment key, level, synchronous to clk.
REQ-010 SHALL have port down, input, 1: decrement key, level, synchronous to clk.
REQ-011 SHALL have port run, input, 1: 1 = timekeeping mode, 0 = set mode.
REQ-012 SHALL have port tick, input, 1: one-cycle increment pulse used in run mode (cascade or time base).
REQ-013 SHALL have port load, input, 1: one-cycle load strobe.
REQ-014 SHALL have port load_bcd, input, 8: BCD value to load, {tens, units}.
REQ-015 SHALL have port value, output, W: binary count.
REQ-016 SHALL have port bcd, output, 8: {tens, units} of value.
REQ-017 SHALL have port carry_out, output, 1: one-cycle pulse on an up-wrap from MAX to 0.
REQ-018 SHALL have port borrow_out, output, 1: one-cycle pulse on a down-wrap from 0 to MAX.
REQ-019 SHALL have port load_err, output, 1: one-cycle pulse when a load is rejected.

Function
REQ-020 SHALL increment, in run mode (run=1), on each cycle with tick=1, wrapping MAX->0 with carry_out=1 in the cycle after the wrap edge.
REQ-021 SHALL ignore up and down while run=1, and SHALL hold the key FSM in IDLE.
REQ-022 SHALL enable stepping in set mode only while run=0 and sel==SEL_ID, and SHALL ignore tick in set mode.
REQ-023 SHALL register up and down once per cycle (up_q, down_q) to detect rising edges.
REQ-024 SHALL implement the key FSM as IDLE -> HOLD -> REPEAT.
REQ-025 IDLE: a rising edge of exactly one key SHALL step once and go to HOLD, with the cycle counter cleared.
REQ-026 HOLD: if the same key is still held when the counter reaches REPEAT_DLY-1, the block SHALL step and go to REPEAT, with the counter cleared.
REQ-027 REPEAT: the block SHALL step every REPEAT_RATE cycles while the key is held.
REQ-028 In HOLD or REPEAT, key release, the other key asserting, or a loss of set-mode enable SHALL return the FSM to IDLE with no step.
REQ-029 If up and down are both 1, the block SHALL not step and SHALL return to IDLE.
REQ-030 A step SHALL use modular arithmetic: up from MAX gives 0 with carry_out; down from 0 gives MAX with borrow_out.
REQ-031 Set-mode wraps SHALL also pulse carry_out or borrow_out.
REQ-032 Load SHALL be accepted when both digits are <=9 and 10*tens+units <= MAX; value then equals the loaded number in the next cycle.
REQ-033 Otherwise load_err SHALL pulse one cycle and value SHALL hold.
REQ-034 Priority in a single cycle SHALL be load > set-mode step > run tick, with only one update per cycle.
REQ-035 A tick that loses arbitration SHALL be dropped.
REQ-036 bcd SHALL be combinational from value (zero latency); value SHALL never exceed MAX.
REQ-037 carry_out, borrow_out and load_err SHALL be registered and mutually exclusive.

Reset
REQ-038 On reset assertion, value, carry_out, borrow_out, load_err, up_q, down_q, the FSM state (IDLE) and the cycle counter SHALL go to 0 immediately.
REQ-039 bcd SHALL read 8'h00 during and after reset.
REQ-040 A key held through reset release SHALL not step until it is released and pressed again, because up_q and down_q sample it first.

Structure
REQ-041 Shared package time_pkg SHALL hold the key FSM state enum, the clog2 width function, and the BCD digit-valid constant (9).
REQ-042 Sub-module bin2bcd_2dig SHALL be combinational: W-bit binary (0..99) to {tens, units}, reused by hour and minute fields.
REQ-043 The repeat counter SHALL be sized to clog2(max(REPEAT_DLY, REPEAT_RATE)).

Verification (bench parameters MAX=59, SEL_ID=1, REPEAT_DLY=8, REPEAT_RATE=4)
REQ-044 Run mode, value=58, two tick pulses -> value 59 then 0; bcd 8'h59 then 8'h00; carry_out high exactly one cycle.
REQ-045 Set mode, sel=1, value=0, one-cycle down press -> value 59, bcd 8'h59, borrow_out one cycle, FSM back in IDLE.
REQ-046 Set mode, up held 20 cycles from value 10 -> steps at press, +8, +12, +16, +20 cycles; value 15.
REQ-047 sel=2, up pressed -> value unchanged; up and down pressed simultaneously with sel=1 -> value unchanged.
REQ-048 load_bcd=8'h45 -> value 45; load_bcd=8'h60 or 8'h3A -> load_err pulse, value held; load together with tick -> loaded value wins.
REQ-049 Reset asserted mid-REPEAT with up held -> value 0 asynchronously; no step after release until up drops and rises again.
